program_loader: RTL and testbench



---
 rtl/program_loader.sv | 187 ++++++++++++++++++
 tb/tb_program_loader.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/program_loader.sv
// Memory-bus initiator: streams DEPTH bytes into the CPU's program memory, optionally
// reads them back for a checksum (macro LOADER_VERIFY_EN), then releases the bus.
module program_loader #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [7:0]        i_data,
    input  logic              i_valid,
    output logic              o_ready,
    output logic [ADDR_W-1:0] o_address,
    output logic              o_bus_en,
    output logic              o_read_n,
    output logic              o_write_n,
    inout  wire  [7:0]        io_bus,
    output logic              o_cpu_hold,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_error
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_WRITE  = 3'd2,
        S_TURN   = 3'd3,
        S_VERIFY = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_PTR  = ADDR_W'(1);

    state_t            state_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        data_q;
    logic [7:0]        sum_q;
    logic              ready_q;
    logic              own_q;
    logic              write_n_q;
    logic              drive_q;
    logic              done_q;

`ifdef LOADER_VERIFY_EN
    logic              read_n_q;
    logic              error_q;
    logic [7:0]        rb_sum_q;
    logic [7:0]        rb_sum_d;

    assign rb_sum_d = rb_sum_q + io_bus;
`endif

    // Loader FSM; every output is a flop loaded with the value for the state being entered
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            addr_q    <= '0;
            data_q    <= 8'h00;
            sum_q     <= 8'h00;
            ready_q   <= 1'b0;
            own_q     <= 1'b0;
            write_n_q <= 1'b1;
            drive_q   <= 1'b0;
            done_q    <= 1'b0;
`ifdef LOADER_VERIFY_EN
            read_n_q  <= 1'b1;
            error_q   <= 1'b0;
            rb_sum_q  <= 8'h00;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    if (i_start) begin
                        state_q <= S_LOAD;
                        ptr_q   <= '0;
                        sum_q   <= 8'h00;
                        ready_q <= 1'b1;
                        own_q   <= 1'b1;
`ifdef LOADER_VERIFY_EN
                        error_q  <= 1'b0;
                        rb_sum_q <= 8'h00;
`endif
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_LOAD: begin
                    if (i_valid) begin
                        state_q   <= S_WRITE;
                        data_q    <= i_data;
                        sum_q     <= sum_q + i_data;
                        ready_q   <= 1'b0;
                        write_n_q <= 1'b0;
                        drive_q   <= 1'b1;
                        addr_q    <= ptr_q;
                    end else begin
                        state_q <= S_LOAD;
                    end
                end
                S_WRITE: begin
                    write_n_q <= 1'b1;
                    drive_q   <= 1'b0;
                    if (ptr_q == LAST_PTR) begin
                        state_q <= S_TURN;
                        addr_q  <= '0;
                    end else begin
                        state_q <= S_LOAD;
                        ptr_q   <= ptr_q + ONE_PTR;
                        addr_q  <= ptr_q + ONE_PTR;
                        ready_q <= 1'b1;
                    end
                end
                S_TURN: begin
                    ptr_q  <= '0;
                    addr_q <= '0;
`ifdef LOADER_VERIFY_EN
                    state_q  <= S_VERIFY;
                    read_n_q <= 1'b0;
                    rb_sum_q <= 8'h00;
`else
                    state_q <= S_DONE;
                    own_q   <= 1'b0;
                    done_q  <= 1'b1;
`endif
                end
`ifdef LOADER_VERIFY_EN
                S_VERIFY: begin
                    rb_sum_q <= rb_sum_d;
                    if (ptr_q == LAST_PTR) begin
                        state_q  <= S_DONE;
                        ptr_q    <= '0;
                        addr_q   <= '0;
                        read_n_q <= 1'b1;
                        own_q    <= 1'b0;
                        done_q   <= 1'b1;
                        error_q  <= (rb_sum_d != sum_q);
                    end else begin
                        state_q <= S_VERIFY;
                        ptr_q   <= ptr_q + ONE_PTR;
                        addr_q  <= ptr_q + ONE_PTR;
                    end
                end
`endif
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    // Unreachable encodings drop straight back to a released bus
                    state_q   <= S_IDLE;
                    ptr_q     <= '0;
                    addr_q    <= '0;
                    ready_q   <= 1'b0;
                    own_q     <= 1'b0;
                    write_n_q <= 1'b1;
                    drive_q   <= 1'b0;
                    done_q    <= 1'b0;
`ifdef LOADER_VERIFY_EN
                    read_n_q  <= 1'b1;
`endif
                end
            endcase
        end
    end

    assign io_bus     = drive_q ? data_q : 8'hzz;
    assign o_ready    = ready_q;
    assign o_address  = addr_q;
    assign o_bus_en   = own_q;
    assign o_cpu_hold = own_q;
    assign o_busy     = own_q;
    assign o_write_n  = write_n_q;
    assign o_done     = done_q;
`ifdef LOADER_VERIFY_EN
    assign o_read_n   = read_n_q;
    assign o_error    = error_q;
`else
    assign o_read_n   = 1'b1;
    assign o_error    = 1'b0;
`endif

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a 16x8 memory model on the shared bus and
// expectations (contents, done latency, error) derived from the stream and its gaps.
module tb_program_loader;

`ifdef LOADER_VERIFY_EN
    localparam bit VERIFY = 1'b1;
`else
    localparam bit VERIFY = 1'b0;
`endif

    logic       clk;
    logic       i_rst_n, i_start, i_valid;
    logic [7:0] i_data;
    logic       o_ready, o_bus_en, o_read_n, o_write_n, o_cpu_hold, o_busy, o_done, o_error;
    logic [3:0] o_address;
    wire  [7:0] io_bus;

    logic [7:0] mem     [16];
    logic [7:0] exp_mem [16];
    logic [7:0] stream  [16];
    int         gaps    [16];
    bit         corrupt;
    int         tests, fails, cyc;
    int         wr_falls, rd_cycles, done_cnt, overlap;

    program_loader #(.DEPTH(16), .ADDR_W(4)) dut (
        .i_clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_data(i_data),
        .i_valid(i_valid), .o_ready(o_ready), .o_address(o_address),
        .o_bus_en(o_bus_en), .o_read_n(o_read_n), .o_write_n(o_write_n),
        .io_bus(io_bus), .o_cpu_hold(o_cpu_hold), .o_busy(o_busy),
        .o_done(o_done), .o_error(o_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory: single-edge write, combinational read; address 5 can be forced to 0x41
    always @(posedge clk) if (o_write_n === 1'b0) mem[o_address] <= io_bus;
    assign io_bus = (o_read_n === 1'b0) ? ((corrupt && o_address == 4'd5) ? 8'h41 : mem[o_address]) : 8'hzz;

    always @(negedge o_write_n) wr_falls++;
    always @(negedge clk) begin
        if (o_read_n === 1'b0) rd_cycles++;
        if (o_done === 1'b1) done_cnt++;
        if (o_ready === 1'b1 && o_write_n === 1'b0) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        cyc++;
    endtask

    task automatic check_released(input string tag);
        check({tag, "_ready"}, o_ready, 1'b0);
        check({tag, "_own"}, {o_busy, o_cpu_hold, o_bus_en}, 3'b000);
        check({tag, "_strobes"}, {o_read_n, o_write_n}, 2'b11);
        check({tag, "_addr"}, o_address, 4'd0);
        check({tag, "_bus"}, io_bus, 8'hzz);
    endtask

    task automatic set_countdown();
        for (int i = 0; i < 16; i++) begin
            stream[i] = 8'h00;
            gaps[i]   = 0;
        end
        stream[0] = 8'h1D; stream[1] = 8'h61; stream[2] = 8'h40; stream[3] = 8'h90;
        stream[4] = 8'hC2; stream[5] = 8'h40; stream[6] = 8'hF0; stream[13] = 8'h3F;
    endtask

    task automatic set_random();
        for (int i = 0; i < 16; i++) begin
            stream[i] = 8'($urandom_range(0, 255));
            gaps[i]   = int'($urandom_range(0, 3));
        end
    endtask

    // One load run; rst_at >= 0 pulls reset in the write cycle of that byte index
    task automatic run_load(input string tag, input bit pulse_start, input int rst_at);
        int wf0, rf0, dn0, exp_done, n, s_wr, s_rd;
        bit exp_err;
        wf0 = wr_falls; rf0 = rd_cycles; dn0 = done_cnt;
        i_start = 1'b1;
        cyc = 0;
        step();
        i_start = 1'b0;
        check({tag, "_load_ready"}, o_ready, 1'b1);
        check({tag, "_load_own"}, {o_busy, o_cpu_hold, o_bus_en}, 3'b111);
        check({tag, "_err_cleared"}, o_error, 1'b0);
        exp_done = 0;
        for (int i = 0; i < 16; i++) begin
            i_valid = 1'b0;
            n = 0;
            while (o_ready !== 1'b1 && n < 4) begin
                step();
                n++;
            end
            for (int g = 0; g < gaps[i]; g++) begin
                if (pulse_start && i == 3 && g == 0) i_start = 1'b1;
                step();
                i_start = 1'b0;
            end
            i_valid = 1'b1;
            i_data  = stream[i];
            check({tag, "_ready_before_accept"}, o_ready, 1'b1);
            step();
            i_valid = 1'b0;
            check({tag, "_write_strobe"}, {o_write_n, o_ready}, 2'b00);
            check({tag, "_write_addr"}, o_address, i[3:0]);
            check({tag, "_write_bus"}, io_bus, stream[i]);
            exp_done += gaps[i] + 2;
            if (i == rst_at) begin
                i_rst_n = 1'b0;
                #1;
                check_released({tag, "_rst"});
                check({tag, "_rst_done_err"}, {o_done, o_error}, 2'b00);
                #1 i_rst_n = 1'b1;
                step();
                step();
                check({tag, "_rst_kept4"}, mem[4], stream[4]);
                check({tag, "_rst_no_write5"}, mem[5], exp_mem[5]);
                for (int k = 0; k < 5; k++) exp_mem[k] = stream[k];
                return;
            end
        end
        exp_done += 2 + (VERIFY ? 16 : 0);
        while (o_done !== 1'b1 && cyc < 200) begin
            i_start = (pulse_start && o_read_n === 1'b0) ? 1'b1 : 1'b0;
            step();
            i_start = 1'b0;
        end
        s_wr = 0; s_rd = 0;
        for (int i = 0; i < 16; i++) begin
            s_wr += stream[i];
            s_rd += (i == 5 && corrupt) ? 8'h41 : stream[i];
        end
        exp_err = VERIFY && ((s_wr % 256) != (s_rd % 256));
        check({tag, "_done_latency"}, cyc, exp_done);
        check({tag, "_done_pulse"}, o_done, 1'b1);
        check({tag, "_done_error"}, o_error, exp_err);
        check_released({tag, "_done"});
        step();
        check({tag, "_done_single"}, o_done, 1'b0);
        check({tag, "_error_holds"}, o_error, exp_err);
        check({tag, "_done_count"}, done_cnt - dn0, 1);
        check({tag, "_write_count"}, wr_falls - wf0, 16);
        check({tag, "_read_count"}, rd_cycles - rf0, VERIFY ? 16 : 0);
        for (int i = 0; i < 16; i++) begin
            check({tag, "_mem"}, {i[3:0], mem[i]}, {i[3:0], stream[i]});
            exp_mem[i] = stream[i];
        end
    endtask

    initial begin
        tests = 0; fails = 0; cyc = 0;
        wr_falls = 0; rd_cycles = 0; done_cnt = 0; overlap = 0;
        corrupt = 1'b0;
        i_start = 1'b0; i_valid = 1'b0; i_data = 8'h00;
        for (int i = 0; i < 16; i++) begin
            mem[i] = 8'h00;
            exp_mem[i] = 8'h00;
        end
        i_rst_n = 1'b1;
        #2 i_rst_n = 1'b0;
        #1;
        check_released("reset");
        check("reset_done_err", {o_done, o_error}, 2'b00);
        step();
        step();
        i_rst_n = 1'b1;
        step();
        check_released("idle");

        set_countdown();
        run_load("countdown", 1'b0, -1);

        set_countdown();
        for (int i = 0; i < 16; i++) gaps[i] = 3;
        run_load("gapped", 1'b0, -1);

        set_countdown();
        corrupt = 1'b1;
        run_load("corrupt", 1'b0, -1);
        repeat (3) step();
        check("corrupt_sticky", o_error, VERIFY);
        corrupt = 1'b0;

        set_random();
        gaps[3] = 1;
        run_load("start_pulses", 1'b1, -1);

        set_random();
        run_load("reset_mid", 1'b0, 5);
        check_released("after_reset");

        set_random();
        run_load("reload", 1'b0, -1);

        check("ready_write_overlap", overlap, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
